canny_frame_sequencer: RTL and testbench

- Frame-timing controller for the Canny pixel-pair datapath: gaussian -> Sobel/gradient -> non-max suppression.
- Sequences one frame as start-up VSYNC delay, then per line an HSYNC gap followed by WIDTH/2 pixel-pair beats.
- Supplies row/col, the memory read strobe and 3x3 window-edge flags to the window/Sobel datapath.
- Honours downstream backpressure and reports end of frame to the BMP writer.

---
 rtl/canny_frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_canny_frame_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/canny_frame_sequencer.sv
// Frame-timing controller for the Canny pixel-pair datapath: VSYNC lead-in, then per line an HSYNC gap and WIDTH/2 pair beats.
// Outputs are a Moore decode of registered state; a low win_ready holds the presented pair until it is accepted.
module canny_frame_sequencer #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic        abort,
    input  logic        win_ready,
    output logic        VSYNC,
    output logic        HSYNC,
    output logic        busy,
    output logic        rd_en,
    output logic        win_valid,
    output logic [9:0]  row,
    output logic [10:0] col,
    output logic        top_edge,
    output logic        bottom_edge,
    output logic        left_edge,
    output logic        right_edge,
    output logic [18:0] pair_count,
    output logic        frame_done
);

    localparam int CNT_MAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SU_LAST  = CNT_W'(START_UP_DELAY);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HSYNC_DELAY);
    localparam logic [9:0]       ROW_LAST = 10'(HEIGHT - 1);
    localparam logic [10:0]      COL_LAST = 11'(WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_VSYNC = 3'd1,
        S_HSYNC = 3'd2,
        S_DATA  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_row;
    logic [10:0]      r_col;
    logic [18:0]      r_pair_count;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [9:0]       w_row_nxt;
    logic [10:0]      w_col_nxt;
    logic [18:0]      w_pair_count_nxt;
    logic             w_accept;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_pair_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_row        <= w_row_nxt;
            r_col        <= w_col_nxt;
            r_pair_count <= w_pair_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_col_nxt        = r_col;
        w_pair_count_nxt = r_pair_count;
        w_accept         = (r_state == S_DATA) && win_ready;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt      = S_VSYNC;
                    w_row_nxt        = '0;
                    w_col_nxt        = '0;
                    w_pair_count_nxt = '0;
                end
            end
            S_VSYNC: begin
                if (r_cnt == SU_LAST) begin
                    w_state_nxt = S_HSYNC;
                end
            end
            S_HSYNC: begin
                if (r_cnt == HS_LAST) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_pair_count_nxt = r_pair_count + 19'd1;
                    if (r_col != COL_LAST) begin
                        w_col_nxt = r_col + 11'd2;
                    end else if (r_row != ROW_LAST) begin
                        w_col_nxt   = '0;
                        w_row_nxt   = r_row + 10'd1;
                        w_state_nxt = S_HSYNC;
                    end else begin
                        // Last pair of the frame: row/col stay on it for the DONE cycle.
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (abort) begin
            w_state_nxt      = S_IDLE;
            w_row_nxt        = '0;
            w_col_nxt        = '0;
            w_pair_count_nxt = '0;
        end

        // Any phase change (or abort) restarts the delay count from zero.
        if (abort || (w_state_nxt != r_state)) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    assign VSYNC       = (r_state == S_VSYNC);
    assign win_valid   = (r_state == S_DATA);
    assign HSYNC       = win_valid;
    assign rd_en       = win_valid;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = (r_state == S_DONE);
    assign row         = r_row;
    assign col         = r_col;
    assign pair_count  = r_pair_count;
    assign top_edge    = (r_row == 10'd0);
    assign bottom_edge = (r_row == ROW_LAST);
    assign left_edge   = (r_col == 11'd0);
    assign right_edge  = (r_col == COL_LAST);

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Randomized scoreboard bench for canny_frame_sequencer on an 8x4 image.
module tb_canny_frame_sequencer;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int SUD   = 3;
    localparam int HSD   = 2;
    localparam int NPAIR = W * H / 2;
    localparam int PATN  = 1024;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        win_ready = 1'b0;
    logic        VSYNC, HSYNC, busy, rd_en, win_valid;
    logic [9:0]  row;
    logic [10:0] col;
    logic        top_edge, bottom_edge, left_edge, right_edge;
    logic [18:0] pair_count;
    logic        frame_done;

    canny_frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HSD)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort),
        .win_ready(win_ready), .VSYNC(VSYNC), .HSYNC(HSYNC), .busy(busy),
        .rd_en(rd_en), .win_valid(win_valid), .row(row), .col(col),
        .top_edge(top_edge), .bottom_edge(bottom_edge), .left_edge(left_edge),
        .right_edge(right_edge), .pair_count(pair_count), .frame_done(frame_done)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int row;
        int col;
        int pc;
    } exp_t;

    exp_t model_q[$];
    exp_t sb[$];
    int   done_q[$];
    bit   pat[0:PATN-1];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_flags"},
              {VSYNC, HSYNC, busy, rd_en, win_valid, frame_done,
               top_edge, bottom_edge, left_edge, right_edge}, 10'b0000001010);
        check({tag, "_row"}, row, 0);
        check({tag, "_col"}, col, 0);
        check({tag, "_pair_count"}, pair_count, 0);
    endtask

    // Reference timeline: cycle 1 is the first VSYNC cycle; a pair is taken
    // on the first DATA cycle whose ready pattern bit is set.
    task automatic build_model(output int done_k, output int hs1_k);
        int k;
        model_q.delete();
        hs1_k = 0;
        k = SUD + 2;
        for (int r = 0; r < H; r++) begin
            if (r == 1) hs1_k = k;
            k += HSD + 1;
            for (int c = 0; c < W; c += 2) begin
                while (k < PATN - 1 && !pat[k]) k++;
                model_q.push_back('{k, r, c, model_q.size()});
                k++;
            end
        end
        done_k = k;
    endtask

    task automatic fill_pat(input int stall_pct);
        for (int i = 0; i < PATN; i++)
            pat[i] = ($urandom_range(0, 99) >= stall_pct);
    endtask

    task automatic run_frame(input int abort_idx, input bit do_rst, input int busy_k);
        int done_k, hs1_k, abort_k, rst_k, c0, last_k;
        build_model(done_k, hs1_k);
        abort_k = (abort_idx >= 0) ? model_q[abort_idx].cyc : -1;
        rst_k   = do_rst ? hs1_k + 1 : -1;
        @(posedge HCLK); #1;
        c0 = cyc;
        foreach (model_q[i]) begin
            if ((abort_k < 0 || model_q[i].cyc <= abort_k) &&
                (rst_k < 0 || model_q[i].cyc < rst_k))
                sb.push_back('{c0 + model_q[i].cyc, model_q[i].row,
                               model_q[i].col, model_q[i].pc});
        end
        if (abort_k < 0 && rst_k < 0) done_q.push_back(c0 + done_k);
        start = 1'b1;
        last_k = (abort_k >= 0) ? abort_k + 2 : ((rst_k >= 0) ? rst_k : done_k + 2);
        for (int k = 1; k <= last_k; k++) begin
            @(posedge HCLK); #1;
            start     = (k == busy_k);
            abort     = (k == abort_k);
            win_ready = pat[k];
            if (k == rst_k) begin
                HRESETn = 1'b0;
                #1;
                check_reset_vals("async_reset");
                sb.delete();
                done_q.delete();
            end else if (k <= SUD + 2 && (abort_k < 0 || k <= abort_k)) begin
                @(negedge HCLK);
                check("vsync_phase", VSYNC, (k <= SUD + 1) ? 1 : 0);
            end else if (abort_k >= 0 && k == abort_k + 1) begin
                @(negedge HCLK);
                check("abort_busy", busy, 0);
                check("abort_pair_count", pair_count, 0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (rst_k >= 0) begin
            repeat (2) @(posedge HCLK);
            #1 HRESETn = 1'b1;
            repeat (3) @(posedge HCLK);
        end
        @(negedge HCLK);
        check("idle_after_frame", busy, 0);
        check("sb_drained", sb.size(), 0);
        check("done_drained", done_q.size(), 0);
    endtask

    always @(negedge HCLK) begin : monitor
        exp_t e;
        if (HRESETn) begin
            if (win_valid) begin
                check("rd_en_hsync", {rd_en, HSYNC}, 2'b11);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pair: row %0d col %0d presented, none expected", row, col);
                end else begin
                    e = sb[0];
                    check("pair_row", row, e.row);
                    check("pair_col", col, e.col);
                    check("pair_count", pair_count, e.pc);
                    check("edges", {top_edge, bottom_edge, left_edge, right_edge},
                          {e.row == 0, e.row == H - 1, e.col == 0, e.col == W - 2});
                    if (win_ready) begin
                        check("pair_cycle", cyc, e.cyc);
                        void'(sb.pop_front());
                    end
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_done: got pulse at cycle %0d, none expected", cyc);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    check("done_pair_count", pair_count, NPAIR);
                end
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_vals("reset");
        @(posedge HCLK); #1 HRESETn = 1'b1;
        repeat (2) @(posedge HCLK);

        // Free-running frame: pair timing, edges and done cycle 33.
        fill_pat(0);
        run_frame(-1, 1'b0, 0);

        // Five-cycle stall while row 1, col 4 is presented.
        fill_pat(0);
        for (int i = 0; i < 5; i++)
            pat[(SUD + 1) + (HSD + 1 + W / 2) + (HSD + 1) + 3 + i] = 1'b0;
        run_frame(-1, 1'b0, 0);

        // Random backpressure with a stray start pulse while busy.
        for (int f = 0; f < 3; f++) begin
            fill_pat(30);
            run_frame(-1, 1'b0, $urandom_range(2, 33));
        end

        // Abort at row 2, col 2, then a complete frame.
        fill_pat(0);
        run_frame(2 * (W / 2) + 1, 1'b0, 0);
        run_frame(-1, 1'b0, 0);

        // start and abort together in IDLE.
        @(posedge HCLK); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge HCLK);
        check("start_abort_busy", busy, 0);
        check("start_abort_vsync", VSYNC, 0);

        // Async reset during line 1 HSYNC, then a clean frame.
        fill_pat(20);
        run_frame(-1, 1'b1, 0);
        run_frame(-1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
